// File: rtl/pll_seq_pkg.sv
// Shared types and default parameters for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    PLL_RESET = 3'd1,
    REL_MEM   = 3'd2,
    REL_FUNC  = 3'd3,
    RUN       = 3'd4
  } pll_seq_state_t;

  localparam int unsigned DEF_LOCK_STABLE   = 1024;
  localparam int unsigned DEF_STAGE_GAP     = 16;
  localparam int unsigned DEF_LOSS_FILTER   = 4;
  localparam int unsigned DEF_TIMEOUT       = 65536;
  localparam int unsigned DEF_PLLRST_CYCLES = 8;

  // States in which at least the memory controller is out of reset.
  function automatic logic in_release(pll_seq_state_t s);
    return (s == REL_MEM) || (s == REL_FUNC) || (s == RUN);
  endfunction

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer with synchronous active-low reset.
module sync_ff2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Filters PLL lock, releases mem/func/cpu resets in order, re-asserts on loss.
// Optional PLL retry on lock timeout: define PLL_LOCK_TIMEOUT_EN.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE   = DEF_LOCK_STABLE,
  parameter int unsigned STAGE_GAP     = DEF_STAGE_GAP,
  parameter int unsigned LOSS_FILTER   = DEF_LOSS_FILTER,
  parameter int unsigned TIMEOUT       = DEF_TIMEOUT,
  parameter int unsigned PLLRST_CYCLES = DEF_PLLRST_CYCLES
) (
  input  logic       clkin,
  input  logic       rstn,
  input  logic       locked,
  output logic       pll_rst,
  output logic       rst_mem_n,
  output logic       rst_func_n,
  output logic       rst_cpu_n,
  output logic       ready,
  output logic [7:0] loss_count
);

  localparam int unsigned STAB_W = $clog2(LOCK_STABLE + 1);
  localparam int unsigned GAP_W  = $clog2(STAGE_GAP + 1);
  localparam int unsigned LOSS_W = $clog2(LOSS_FILTER + 1);
  localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(LOCK_STABLE - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(STAGE_GAP - 1);
  localparam logic [LOSS_W-1:0] LOSS_LIMIT = LOSS_W'(LOSS_FILTER);

  if (LOCK_STABLE == 0 || STAGE_GAP == 0 || LOSS_FILTER == 0 ||
      TIMEOUT == 0 || PLLRST_CYCLES == 0) begin : g_param_check
    $error("pll_lock_sequencer: all cycle-count parameters must be >= 1");
  end

  pll_seq_state_t    state_q, state_d;
  logic              locked_s;
  logic              sync_rst_n;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [LOSS_W-1:0] lossf_q, lossf_d;
  logic              lock_stable, stage_done, lock_lost;
  logic              rst_mem_n_q, rst_func_n_q, rst_cpu_n_q, ready_q;
  logic              rst_mem_n_d, rst_func_n_d, rst_cpu_n_d, ready_d;
  logic [7:0]        loss_count_q, loss_count_d;

`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned PRC_W = $clog2(PLLRST_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [PRC_W-1:0] PRC_LAST = PRC_W'(PLLRST_CYCLES - 1);

  logic [TO_W-1:0]  to_q, to_d;
  logic [PRC_W-1:0] prc_q, prc_d;
  logic             timeout_hit, prst_done;
  logic             pll_rst_q, pll_rst_d;

  assign timeout_hit = (to_q == TO_LAST);
  assign prst_done   = (state_q == PLL_RESET) && (prc_q == PRC_LAST);
  // Leaving PLL_RESET also wipes the synchronizer history.
  assign sync_rst_n  = rstn & ~prst_done;
  assign pll_rst     = pll_rst_q & rstn;
`else
  assign sync_rst_n  = rstn;
  assign pll_rst     = 1'b0;
`endif

  sync_ff2 u_sync (
    .clk_i  (clkin),
    .rst_ni (sync_rst_n),
    .d_i    (locked),
    .q_o    (locked_s)
  );

  assign lock_stable = locked_s && (stab_q == STAB_LAST);
  assign stage_done  = (gap_q == GAP_LAST);
  assign lock_lost   = (lossf_q == LOSS_LIMIT);

  always_ff @(posedge clkin) begin
    if (!rstn) state_q <= WAIT_LOCK;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_stable) state_d = REL_MEM;
`ifdef PLL_LOCK_TIMEOUT_EN
        else if (timeout_hit) state_d = PLL_RESET;
`endif
      end
`ifdef PLL_LOCK_TIMEOUT_EN
      PLL_RESET: if (prst_done) state_d = WAIT_LOCK;
`endif
      REL_MEM: begin
        if (lock_lost)       state_d = WAIT_LOCK;
        else if (stage_done) state_d = REL_FUNC;
      end
      REL_FUNC: begin
        if (lock_lost)       state_d = WAIT_LOCK;
        else if (stage_done) state_d = RUN;
      end
      RUN:     if (lock_lost) state_d = WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Counters run only while the FSM stays put, so every state entry starts from zero.
  always_comb begin
    stab_d  = (state_q == WAIT_LOCK && state_d == WAIT_LOCK && locked_s) ? stab_q + 1'b1 : '0;
    gap_d   = (state_d == state_q && (state_q == REL_MEM || state_q == REL_FUNC))
              ? gap_q + 1'b1 : '0;
    lossf_d = (in_release(state_q) && in_release(state_d) && !locked_s) ? lossf_q + 1'b1 : '0;
`ifdef PLL_LOCK_TIMEOUT_EN
    to_d    = (state_q == WAIT_LOCK && state_d == WAIT_LOCK) ? to_q + 1'b1 : '0;
    prc_d   = (state_q == PLL_RESET && state_d == PLL_RESET) ? prc_q + 1'b1 : '0;
`endif
  end

  always_ff @(posedge clkin) begin
    if (!rstn) begin
      stab_q  <= '0;
      gap_q   <= '0;
      lossf_q <= '0;
`ifdef PLL_LOCK_TIMEOUT_EN
      to_q    <= '0;
      prc_q   <= '0;
`endif
    end else begin
      stab_q  <= stab_d;
      gap_q   <= gap_d;
      lossf_q <= lossf_d;
`ifdef PLL_LOCK_TIMEOUT_EN
      to_q    <= to_d;
      prc_q   <= prc_d;
`endif
    end
  end

  // Outputs are decoded from the next state so they change on the entry edge.
  always_comb begin
    rst_mem_n_d  = in_release(state_d);
    rst_func_n_d = (state_d == REL_FUNC) || (state_d == RUN);
    rst_cpu_n_d  = (state_d == RUN);
    ready_d      = (state_d == RUN);
    loss_count_d = loss_count_q;
    if (in_release(state_q) && lock_lost && loss_count_q != '1)
      loss_count_d = loss_count_q + 8'd1;
`ifdef PLL_LOCK_TIMEOUT_EN
    pll_rst_d    = (state_d == PLL_RESET);
`endif
  end

  always_ff @(posedge clkin) begin
    if (!rstn) begin
      rst_mem_n_q  <= 1'b0;
      rst_func_n_q <= 1'b0;
      rst_cpu_n_q  <= 1'b0;
      ready_q      <= 1'b0;
      loss_count_q <= '0;
`ifdef PLL_LOCK_TIMEOUT_EN
      pll_rst_q    <= 1'b0;
`endif
    end else begin
      rst_mem_n_q  <= rst_mem_n_d;
      rst_func_n_q <= rst_func_n_d;
      rst_cpu_n_q  <= rst_cpu_n_d;
      ready_q      <= ready_d;
      loss_count_q <= loss_count_d;
`ifdef PLL_LOCK_TIMEOUT_EN
      pll_rst_q    <= pll_rst_d;
`endif
    end
  end

  assign rst_mem_n  = rst_mem_n_q;
  assign rst_func_n = rst_func_n_q;
  assign rst_cpu_n  = rst_cpu_n_q;
  assign ready      = ready_q;
  assign loss_count = loss_count_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer; reference model built from edge-indexed
// histories of the synchronized lock signal. Honors PLL_LOCK_TIMEOUT_EN.
module tb_pll_lock_sequencer;

  localparam int LS = 8;
  localparam int SG = 4;
  localparam int LF = 3;
  localparam int TO = 32;
  localparam int PR = 5;
  localparam int MAXE = 16384;
`ifdef PLL_LOCK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int PH_WAIT = 0;
  localparam int PH_PRST = 1;
  localparam int PH_MEM  = 2;
  localparam int PH_FUNC = 3;
  localparam int PH_RUN  = 4;

  logic       clkin = 1'b0;
  logic       rstn;
  logic       locked;
  logic       pll_rst, rst_mem_n, rst_func_n, rst_cpu_n, ready;
  logic [7:0] loss_count;

  pll_lock_sequencer #(
    .LOCK_STABLE   (LS),
    .STAGE_GAP     (SG),
    .LOSS_FILTER   (LF),
    .TIMEOUT       (TO),
    .PLLRST_CYCLES (PR)
  ) dut (
    .clkin      (clkin),
    .rstn       (rstn),
    .locked     (locked),
    .pll_rst    (pll_rst),
    .rst_mem_n  (rst_mem_n),
    .rst_func_n (rst_func_n),
    .rst_cpu_n  (rst_cpu_n),
    .ready      (ready),
    .loss_count (loss_count)
  );

  always #20 clkin = ~clkin;

  typedef struct packed {
    logic       pll_rst;
    logic       mem;
    logic       func;
    logic       cpu;
    logic       rdy;
    logic [7:0] lc;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: edge n history, phase with entry timestamps.
  bit lk_h[0:MAXE-1];
  bit ls_h[0:MAXE-1];
  int n       = 0;
  int phase   = PH_WAIT;
  int ent     = 0;
  int rel_ent = 0;
  int clr     = -10;
  int lcnt    = 0;

  function automatic bit all_ls(int lo, int hi, bit v);
    for (int j = lo; j <= hi; j++)
      if (ls_h[j] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit lk, input bit rn);
    obs_t e;
    if (n >= MAXE) begin
      $display("FAIL model-capacity: edge=%0d limit=%0d", n, MAXE);
      $fatal(1, "edge history exhausted");
    end
    lk_h[n] = lk;
    if (!rn) begin
      phase = PH_WAIT; ent = n; clr = n; lcnt = 0;
    end else if (phase == PH_WAIT) begin
      if (n - LS >= ent && all_ls(n - LS, n - 1, 1'b1)) begin
        phase = PH_MEM; ent = n; rel_ent = n;
      end else if (TO_EN && n == ent + TO) begin
        phase = PH_PRST; ent = n;
      end
    end else if (phase == PH_PRST) begin
      if (n == ent + PR) begin
        phase = PH_WAIT; ent = n; clr = n;
      end
    end else begin
      if (n - 1 - LF >= rel_ent && all_ls(n - 1 - LF, n - 2, 1'b0)) begin
        phase = PH_WAIT; ent = n;
        if (lcnt < 255) lcnt++;
      end else if (phase == PH_MEM && n == rel_ent + SG) begin
        phase = PH_FUNC;
      end else if (phase == PH_FUNC && n == rel_ent + 2 * SG) begin
        phase = PH_RUN;
      end
    end
    ls_h[n] = (clr == n || n - 1 <= clr) ? 1'b0 : lk_h[n-1];
    e.pll_rst = (phase == PH_PRST);
    e.mem     = (phase >= PH_MEM);
    e.func    = (phase >= PH_FUNC);
    e.cpu     = (phase == PH_RUN);
    e.rdy     = (phase == PH_RUN);
    e.lc      = 8'(lcnt);
    exp_q.push_back(e);
    n++;
  endtask

  task automatic step(input bit lk, input bit rn);
    locked = lk;
    rstn   = rn;
    model_step(lk, rn);
    @(negedge clkin);
  endtask

  // Monitor: every edge presents a full output set.
  int   edge_cnt  = 0;
  int   mem_rise  = -1;
  int   func_rise = -1;
  int   cpu_rise  = -1;
  int   rdy_rise  = -1;
  obs_t prev_obs  = '0;

  initial begin : monitor
    obs_t got, e;
    forever begin
      @(posedge clkin);
      #1;
      got = {pll_rst, rst_mem_n, rst_func_n, rst_cpu_n, ready, loss_count};
      if (!prev_obs.mem  && got.mem)  mem_rise  = edge_cnt;
      if (!prev_obs.func && got.func) func_rise = edge_cnt;
      if (!prev_obs.cpu  && got.cpu)  cpu_rise  = edge_cnt;
      if (!prev_obs.rdy  && got.rdy)  rdy_rise  = edge_cnt;
      prev_obs = got;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL outputs@edge%0d: got pll_rst=%b mem=%b func=%b cpu=%b ready=%b lc=%0d, expected pll_rst=%b mem=%b func=%b cpu=%b ready=%b lc=%0d",
                   edge_cnt, got.pll_rst, got.mem, got.func, got.cpu, got.rdy, got.lc,
                   e.pll_rst, e.mem, e.func, e.cpu, e.rdy, e.lc);
        end
      end
      edge_cnt++;
    end
  end

  task automatic check_int(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  initial begin : driver
    int base;
    int len;
    bit v;
    bit r;

    // Reset with locked already high; last reset edge is the reference edge 0.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    base = n - 1;
    for (int i = 0; i < 25; i++) step(1'b1, 1'b1);
    check_int("mem_rise_edge",  mem_rise  - base, 2 + LS);
    check_int("func_rise_edge", func_rise - base, 2 + LS + SG);
    check_int("cpu_rise_edge",  cpu_rise  - base, 2 + LS + 2 * SG);
    check_int("ready_rise_edge", rdy_rise - base, 2 + LS + 2 * SG);

    // Short dropout is filtered, one cycle longer is a loss.
    for (int i = 0; i < 2; i++)  step(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++)  step(1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
    check_int("loss_count_after_first_loss", int'(loss_count), 1);

    // Lock toggling every 5 cycles never settles.
    for (int i = 0; i < 80; i++) step(((i / 5) % 2) == 1, 1'b1);

    // Lock absent for a long time.
    for (int i = 0; i < 1000; i++) step(1'b0, 1'b1);

    // Reset pulse in the middle of the release sequence.
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);

    // Repeated loss events drive the counter into saturation.
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
      for (int i = 0; i < 6; i++)  step(1'b0, 1'b1);
    end
    check_int("loss_count_saturated", int'(loss_count), 255);

    // Random lock runs with occasional resets.
    for (int k = 0; k < 200; k++) begin
      v   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 14));
      r   = ($urandom_range(0, 39) != 0);
      for (int j = 0; j < len; j++) step(v, (j == 0) ? r : 1'b1);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);

    @(posedge clkin);
    #2;
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Consumes the PLL `locked` status and drives the PLL `RST` request, closing the loop on the clock generator. Filters lock, releases staged active-low resets (memory controller, CPU function units, CPU) in order, and re-asserts them on lock loss. Optionally retries a PLL that fails to lock by pulsing its reset. Sits beside the clock generator in the top level and runs on the 25 MHz board clock.

## Interface
Parameters:
- `LOCK_STABLE`, 1024: consecutive synchronized-lock cycles required before release.
- `STAGE_GAP`, 16: cycles between successive reset releases.
- `LOSS_FILTER`, 4: consecutive unlocked cycles that count as lock loss.
- `TIMEOUT`, 65536: cycles in WAIT_LOCK before a PLL reset retry.
- `PLLRST_CYCLES`, 8: width of the `pll_rst` pulse, in cycles.

Ports:
- Reset policy (already decided): one clock, `clkin`; reset `rstn` is synchronous and active-low.
- `clkin` in 1: 25 MHz board clock; all logic on its rising edge.
- `rstn` in 1: synchronous active-low reset.
- `locked` in 1: PLL lock, asynchronous to `clkin`.
- `pll_rst` out 1: active-high reset to PLL `RST`.
- `rst_mem_n` out 1: memory controller reset, active-low.
- `rst_func_n` out 1: CPU function-unit reset, active-low.
- `rst_cpu_n` out 1: CPU reset, active-low.
- `ready` out 1: all domains released.
- `loss_count` out 8: lock-loss events, saturating.

## Operation
- `locked` passes through a 2-FF synchronizer, giving `locked_s`. Nothing else samples raw `locked`.
- States: WAIT_LOCK, PLL_RESET, REL_MEM, REL_FUNC, RUN.
- Reset values: state WAIT_LOCK; `pll_rst`=0; all `rst_*_n`=0; `ready`=0; `loss_count`=0; all counters 0; synchronizer flops 0.
- WAIT_LOCK:
  - Stable counter increments while `locked_s`=1 and clears when `locked_s`=0.
  - When the counter reaches `LOCK_STABLE`-1 with `locked_s`=1, go to REL_MEM.
  - Timeout counter increments every cycle. At `TIMEOUT`-1 go to PLL_RESET (only with the macro defined; see Configuration).
  - If the stable and timeout conditions occur in the same cycle, REL_MEM wins.
- PLL_RESET:
  - `pll_rst`=1 for exactly `PLLRST_CYCLES` cycles, then return to WAIT_LOCK.
  - On that return, both counters and the synchronizer history are cleared.
- REL_MEM: `rst_mem_n`=1 from entry. After `STAGE_GAP` cycles go to REL_FUNC.
- REL_FUNC: `rst_func_n`=1 from entry. After `STAGE_GAP` cycles go to RUN.
- RUN: `rst_cpu_n`=1 and `ready`=1.
- Lock loss:
  - Applies in REL_MEM, REL_FUNC and RUN.
  - The loss counter counts consecutive `locked_s`=0 cycles and clears on any `locked_s`=1.
  - When it reaches `LOSS_FILTER`, on the next edge: all `rst_*_n`=0, `ready`=0, go to WAIT_LOCK, and `loss_count` increments.
  - `loss_count` saturates at 255.
  - Loss takes priority over a stage transition in the same cycle.
- `rstn`=0 at any time forces the reset values on the next edge, mid-sequence included; `pll_rst` drops immediately.
- Resets de-assert strictly in the order mem, func, cpu, and always re-assert together.

## Timing
- All outputs are registered; none is combinational from `locked`.
- With `locked`=1 held from reset release (edge 0):
  - `locked_s` is 1 at edge 2.
  - `rst_mem_n` rises at edge 2+`LOCK_STABLE`.
  - `rst_func_n` rises `STAGE_GAP` edges after that.
  - `rst_cpu_n` and `ready` rise `STAGE_GAP` edges after that.
- Loss latency: from the edge on which `locked` first samples 0, the resets fall at edge 2+`LOSS_FILTER`.
- `pll_rst` asserts on the edge after the timeout and stays high for exactly `PLLRST_CYCLES` edges.
- Counter widths: `$clog2(param+1)`.

## Configuration
- Macro: `PLL_LOCK_TIMEOUT_EN`.
- Defined: the timeout counter and the PLL_RESET state are present.
- Undefined:
  - WAIT_LOCK waits indefinitely.
  - `pll_rst` is tied to 0.
  - The PLL_RESET state and the timeout counter are not synthesized.

## Structure
- Package `pll_seq_pkg`: state enum `pll_seq_state_t` and default parameter constants.
- Sub-module `sync_ff2`: 2-FF synchronizer with synchronous active-low reset.
- Everything else lives in one FSM plus counters.

## Test plan
Bench parameters: `LOCK_STABLE`=8, `STAGE_GAP`=4, `LOSS_FILTER`=3, `TIMEOUT`=32, `PLLRST_CYCLES`=5.
- `locked`=1 from edge 0 → `rst_mem_n`↑ at edge 10, `rst_func_n`↑ at 14, `rst_cpu_n`/`ready`↑ at 18.
- In RUN, drop `locked` for 2 cycles → no change. Drop it for 3 cycles → all resets 0 at edge 5 after the drop, and `loss_count`=1.
- `locked` toggles every 5 cycles → `rst_mem_n` stays 0. With the macro defined: `pll_rst` high for cycles 33–37, then the sequence retries.
- `locked`=0 forever, macro undefined → `pll_rst` stays 0 and state stays WAIT_LOCK for 1000 cycles.
- `rstn`=0 for one cycle while in REL_FUNC → next edge all resets 0, `loss_count`=0, and the sequence restarts at edge 10 after release.
- 300 forced loss events → `loss_count` saturates at 255.
